// File: rtl/core_init_pkg.sv
// core_init_pkg: state encoding and width helpers shared by the init sequencer files
package core_init_pkg;
  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    SETTLE     = 3'd1,
    WAIT_READY = 3'd2,
    RUN        = 3'd3,
    FAULT      = 3'd4
  } state_t;

  function automatic int stage_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int timer_w(input int s, input int t);
    return $clog2(((s > t) ? s : t) + 1);
  endfunction
endpackage

// File: rtl/core_init_timer.sv
// core_init_timer: clear/enable up-counter whose done flag compares against a terminal value
module core_init_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         done
);
  logic [W-1:0] count;

  always_ff @(posedge clk)
    if (rst || clr) count <= '0;
    else if (en) count <= count + 1'b1;

  assign done = count == term;
endmodule

// File: rtl/core_init_sequencer.sv
// core_init_sequencer: releases per-stage resets one at a time after PLL lock, with per-stage ready timeouts and fault reporting
module core_init_sequencer
  import core_init_pkg::*;
#(
  parameter int NUM_STAGES   = 3,
  parameter int SETTLE_CLKS  = 16,
  parameter int TIMEOUT_CLKS = 1024
) (
  input  logic                              i_clk,
  input  logic                              i_srst,
  input  logic                              i_pll_locked,
  input  logic                              i_restart,
  input  logic [NUM_STAGES-1:0]             i_stage_ready,
  output logic [NUM_STAGES-1:0]             o_stage_rst,
  output logic                              o_all_ready,
  output logic                              o_fault,
  output logic [stage_w(NUM_STAGES)-1:0]    o_fault_stage,
  output logic [2:0]                        o_state
);
  localparam int SW = stage_w(NUM_STAGES);
  localparam int TW = timer_w(SETTLE_CLKS, TIMEOUT_CLKS);
  localparam logic [NUM_STAGES-1:0] ONE = NUM_STAGES'(1);

  state_t state, state_n;
  logic [SW-1:0] k, k_n, fault_stage_n, bad, flt_idx;
  logic [NUM_STAGES-1:0] stage_rst_n;
  logic all_ready_n, fault_n, drop, flt_go, last;
  logic tmr_clr, tmr_en, tmr_done;
  logic [TW-1:0] term;

  assign o_state = state;
  assign last = int'(k) == NUM_STAGES - 1;
  assign term = (state == SETTLE) ? TW'(SETTLE_CLKS - 1) : TW'(TIMEOUT_CLKS - 1);

  core_init_timer #(.W(TW)) u_timer (
    .clk (i_clk),
    .rst (i_srst),
    .clr (tmr_clr),
    .en  (tmr_en),
    .term(term),
    .done(tmr_done)
  );

  always_comb begin
    drop = 1'b0;
    bad = '0;
    for (int j = NUM_STAGES - 1; j >= 0; j--)
      if (!i_stage_ready[j] && (state == RUN || j < int'(k))) begin
        drop = 1'b1;
        bad = SW'(j);
      end
  end

  always_comb begin
    state_n = state;
    k_n = k;
    stage_rst_n = o_stage_rst;
    all_ready_n = o_all_ready;
    fault_n = o_fault;
    fault_stage_n = o_fault_stage;
    tmr_clr = 1'b1;
    tmr_en = 1'b0;
    flt_go = 1'b0;
    flt_idx = bad;
    if (i_restart || !i_pll_locked) begin
      state_n = WAIT_LOCK;
      k_n = '0;
      stage_rst_n = '1;
      all_ready_n = 1'b0;
      fault_n = 1'b0;
      fault_stage_n = '0;
    end else begin
      case (state)
        WAIT_LOCK: state_n = SETTLE;
        SETTLE:
          if (tmr_done) begin
            state_n = WAIT_READY;
            k_n = '0;
            stage_rst_n[0] = 1'b0;
          end else begin
            tmr_clr = 1'b0;
            tmr_en = 1'b1;
          end
        WAIT_READY:
          if (drop) flt_go = 1'b1;
          else if (i_stage_ready[k]) begin
            if (last) begin
              state_n = RUN;
              all_ready_n = 1'b1;
            end else begin
              stage_rst_n = o_stage_rst & ~(ONE << (k + 1'b1));
              k_n = k + 1'b1;
            end
          end else if (tmr_done) begin
            flt_go = 1'b1;
            flt_idx = k;
          end else begin
            tmr_clr = 1'b0;
            tmr_en = 1'b1;
          end
        RUN: flt_go = drop;
        default: ;
      endcase
      if (flt_go) begin
        state_n = FAULT;
        fault_n = 1'b1;
        stage_rst_n = '1;
        all_ready_n = 1'b0;
        fault_stage_n = flt_idx;
      end
    end
  end

  always_ff @(posedge i_clk)
    if (i_srst) begin
      state <= WAIT_LOCK;
      k <= '0;
      o_stage_rst <= '1;
      o_all_ready <= 1'b0;
      o_fault <= 1'b0;
      o_fault_stage <= '0;
    end else begin
      state <= state_n;
      k <= k_n;
      o_stage_rst <= stage_rst_n;
      o_all_ready <= all_ready_n;
      o_fault <= fault_n;
      o_fault_stage <= fault_stage_n;
    end
endmodule

// File: tb/tb_core_init_sequencer.sv
// tb_core_init_sequencer: scoreboard bench comparing output change events against a behavioural model
module tb_core_init_sequencer;
  localparam int N = 3, S = 4, T = 8;

  typedef struct {
    int         cyc;
    logic [N-1:0] rst;
    logic       ar;
    logic       f;
    logic [1:0] fs;
    logic [2:0] st;
  } obs_t;

  logic i_clk = 1'b0, i_srst = 1'b1, i_pll_locked = 1'b1, i_restart = 1'b0;
  logic [N-1:0] i_stage_ready = '0;
  logic [N-1:0] o_stage_rst;
  logic o_all_ready, o_fault;
  logic [1:0] o_fault_stage;
  logic [2:0] o_state;

  always #5 i_clk = ~i_clk;

  core_init_sequencer #(.NUM_STAGES(N), .SETTLE_CLKS(S), .TIMEOUT_CLKS(T)) dut (
    .i_clk        (i_clk),
    .i_srst       (i_srst),
    .i_pll_locked (i_pll_locked),
    .i_restart    (i_restart),
    .i_stage_ready(i_stage_ready),
    .o_stage_rst  (o_stage_rst),
    .o_all_ready  (o_all_ready),
    .o_fault      (o_fault),
    .o_fault_stage(o_fault_stage),
    .o_state      (o_state)
  );

  int errors = 0, checks = 0, cyc = 0;
  obs_t exp_q[$];
  obs_t m_prev, d_prev;
  bit mon_on = 0;

  int settling = 0, cnt = 0, rel = 0, fs = 0;
  bit allok = 0, flt = 0;

  int age[N], dly[N], cfg[N];
  logic [N-1:0] drop = '0;

  function automatic bit same(obs_t a, obs_t b);
    return {a.rst, a.ar, a.f, a.fs, a.st} === {b.rst, b.ar, b.f, b.fs, b.st};
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("cyc=%0d rst=%b ar=%b f=%b fs=%0d st=%0d", o.cyc, o.rst, o.ar, o.f, o.fs, o.st);
  endfunction

  function automatic int lowest_zero(logic [N-1:0] r, int lim);
    for (int j = 0; j < lim; j++) if (!r[j]) return j;
    return -1;
  endfunction

  function automatic void trip(int idx);
    flt = 1;
    allok = 0;
    fs = idx;
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    logic [N-1:0] ones;
    ones = '1;
    o.cyc = cyc;
    o.rst = flt ? ones : ones << rel;
    o.ar = allok;
    o.f = flt;
    o.fs = 2'(fs);
    o.st = flt ? 3'd4 : allok ? 3'd3 : (rel > 0) ? 3'd2 : settling ? 3'd1 : 3'd0;
    return o;
  endfunction

  // Reference model: counts released stages and elapsed clocks directly.
  always @(posedge i_clk) begin
    obs_t o;
    int k, low;
    cyc++;
    if (i_srst || !i_pll_locked || i_restart) begin
      settling = 0; cnt = 0; rel = 0; allok = 0; flt = 0; fs = 0;
    end else if (flt) begin
    end else if (allok) begin
      low = lowest_zero(i_stage_ready, N);
      if (low >= 0) trip(low);
    end else if (rel > 0) begin
      k = rel - 1;
      low = lowest_zero(i_stage_ready, k);
      if (low >= 0) trip(low);
      else if (i_stage_ready[k]) begin
        if (rel == N) allok = 1;
        else begin rel++; cnt = 0; end
      end else if (cnt == T - 1) trip(k);
      else cnt++;
    end else if (settling) begin
      if (cnt == S - 1) begin rel = 1; cnt = 0; end
      else cnt++;
    end else begin
      settling = 1; cnt = 0;
    end
    o = model_out();
    if (mon_on && !same(o, m_prev)) exp_q.push_back(o);
    m_prev = o;
  end

  // Monitor: every output change must match the next expected event in the same cycle.
  always @(negedge i_clk) if (mon_on) begin
    obs_t d, e;
    d.cyc = cyc; d.rst = o_stage_rst; d.ar = o_all_ready; d.f = o_fault; d.fs = o_fault_stage; d.st = o_state;
    if (!same(d, d_prev)) begin
      checks++;
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        errors++;
        $display("FAIL unexpected_change got %s required no change", fmt(d));
      end else begin
        e = exp_q.pop_front();
        if (!same(d, e)) begin
          errors++;
          $display("FAIL event got %s required %s", fmt(d), fmt(e));
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      checks++;
      errors++;
      e = exp_q.pop_front();
      $display("FAIL missed_event got %s required %s", fmt(d), fmt(e));
    end
    d_prev = d;
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", nm, got, want);
    end
  endtask

  function automatic int pick();
    int r;
    r = $urandom_range(1, 10);
    return (r == 10) ? 1000 : r;
  endfunction

  // Each stage raises ready dly[n] clocks after its reset falls.
  task automatic step(int n);
    repeat (n) begin
      @(negedge i_clk);
      for (int s = 0; s < N; s++) begin
        if (o_stage_rst[s] !== 1'b0) begin
          age[s] = 0;
          dly[s] = (cfg[s] >= 0) ? cfg[s] : pick();
        end else age[s]++;
        i_stage_ready[s] = (o_stage_rst[s] === 1'b0) && age[s] >= dly[s] && !drop[s];
      end
    end
  endtask

  task automatic restart();
    i_restart = 1'b1;
    step(1);
    i_restart = 1'b0;
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_stage_rst"}, 32'(o_stage_rst), 32'h7);
    chk({tag, "_all_ready"}, 32'(o_all_ready), 0);
    chk({tag, "_fault"}, 32'(o_fault), 0);
    chk({tag, "_fault_stage"}, 32'(o_fault_stage), 0);
    chk({tag, "_state"}, 32'(o_state), 0);
  endtask

  initial begin
    int lk;
    cfg = '{2, 2, 2};
    step(3);
    chk_reset("reset");
    d_prev.rst = o_stage_rst; d_prev.ar = o_all_ready; d_prev.f = o_fault;
    d_prev.fs = o_fault_stage; d_prev.st = o_state; d_prev.cyc = cyc;
    mon_on = 1;
    i_srst = 1'b0;
    step(30);
    chk("happy_all_ready", 32'(o_all_ready), 1);
    chk("happy_stage_rst", 32'(o_stage_rst), 0);
    chk("happy_state", 32'(o_state), 3);
    chk("happy_fault", 32'(o_fault), 0);

    cfg = '{2, 1000, 2};
    restart();
    step(40);
    chk("timeout_fault", 32'(o_fault), 1);
    chk("timeout_stage", 32'(o_fault_stage), 1);
    chk("timeout_stage_rst", 32'(o_stage_rst), 32'h7);

    cfg = '{2, 2, 8};
    restart();
    chk("restart_fault_clear", 32'(o_fault), 0);
    step(40);
    chk("race_all_ready", 32'(o_all_ready), 1);
    chk("race_fault", 32'(o_fault), 0);

    drop = 3'b101;
    step(1);
    drop = '0;
    step(1);
    chk("dropout_fault", 32'(o_fault), 1);
    chk("dropout_stage", 32'(o_fault_stage), 0);
    chk("dropout_all_ready", 32'(o_all_ready), 0);

    cfg = '{2, 2, 2};
    restart();
    step(3);
    i_pll_locked = 1'b0;
    step(3);
    chk("lockloss_stage_rst", 32'(o_stage_rst), 32'h7);
    chk("lockloss_state", 32'(o_state), 0);
    i_pll_locked = 1'b1;
    step(25);
    chk("relock_state", 32'(o_state), 3);
    i_srst = 1'b1;
    step(1);
    chk_reset("srst_in_run");
    i_srst = 1'b0;

    cfg = '{-1, -1, -1};
    lk = 0;
    repeat (2500) begin
      i_srst = ($urandom_range(0, 299) == 0);
      if (lk == 0 && $urandom_range(0, 79) == 0) lk = $urandom_range(1, 3);
      i_pll_locked = (lk == 0);
      if (lk > 0) lk--;
      i_restart = ($urandom_range(0, 99) == 0);
      drop = ($urandom_range(0, 24) == 0) ? N'($urandom_range(1, 7)) : '0;
      step(1);
    end
    i_srst = 1'b0; i_restart = 1'b0; i_pll_locked = 1'b1; drop = '0;
    step(5);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
